// File: rtl/fetch_unit_pkg.sv
// Shared types for the tiny5 fetch front end: IF/ID payload, fetch FSM states and queue entries.
package fetch_unit_pkg;

    typedef logic [31:0] instruction_t;

    typedef struct packed {
        logic [31:0]  pc;
        instruction_t instr;
        logic         valid;
    } pipeline_if_id_reg_t;

    typedef enum logic {S_BOOT, S_RUN} fetch_state_t;

    typedef struct packed {
        logic [31:0]  pc;
        instruction_t instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with flush; used as the request pc queue and the prefetch queue.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          push_i,
    input  fetch_entry_t  data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = r_mem[r_rptr];
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage is not reset: only slots below r_count are ever presented as valid.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wptr] <= data_i;
    end

    overflow_a: assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(push_i && full_o && !w_pop && !flush_i));

endmodule

// File: rtl/fetch_unit.sv
// tiny5 instruction fetch: in-order imem requests, prefetch FIFO, redirect flush with discard counting.
// Define FETCH_BYPASS_EN to present a response on if_id_o in its arrival cycle when the FIFO is empty.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                redirect_valid_i,
    input  logic [31:0]         redirect_pc_i,
    input  logic                stall_i,
    output logic                imem_req_valid_o,
    input  logic                imem_req_ready_i,
    output logic [31:0]         imem_req_addr_o,
    input  logic                imem_rsp_valid_i,
    input  logic [31:0]         imem_rsp_data_i,
    output pipeline_if_id_reg_t if_id_o
);

    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

    fetch_state_t  r_state;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_discard;

    logic [CW-1:0] w_inflight;
    logic [CW-1:0] w_occupancy;
    logic [CW:0]   w_credits_used;
    fetch_entry_t  w_pcq_in;
    fetch_entry_t  w_pcq_head;
    fetch_entry_t  w_pfq_in;
    fetch_entry_t  w_pfq_head;
    logic          w_pcq_full;
    logic          w_pcq_empty;
    logic          w_pfq_full;
    logic          w_pfq_empty;
    logic          w_req_fire;
    logic          w_rsp_keep;
    logic          w_bypass;
    logic          w_out_valid;
    logic          w_pfq_push;
    logic          w_pfq_pop;
    logic          w_unused;

    // Pending discards stay inside inflight, so credits cover them until they drain.
    assign w_credits_used   = {1'b0, w_inflight} + {1'b0, w_occupancy};
    assign imem_req_valid_o = (r_state == S_RUN) && !redirect_valid_i && (w_credits_used < CREDITS);
    assign imem_req_addr_o  = r_fetch_pc;
    assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;

    assign w_pcq_in   = '{pc: r_fetch_pc, instr: '0};
    assign w_pfq_in   = '{pc: w_pcq_head.pc, instr: imem_rsp_data_i};
    assign w_rsp_keep = imem_rsp_valid_i && !redirect_valid_i && (r_discard == '0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_rsp_keep && w_pfq_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_out_valid = (!w_pfq_empty || w_bypass) && !redirect_valid_i;
    assign w_pfq_pop   = !w_pfq_empty && !redirect_valid_i && !stall_i;
    assign w_pfq_push  = w_rsp_keep && !(w_bypass && !stall_i);

    // Every response pops its pc, discarded or not, keeping the queue aligned with inflight.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push_i   (w_req_fire),
        .data_i   (w_pcq_in),
        .pop_i    (imem_rsp_valid_i),
        .flush_i  (1'b0),
        .head_o   (w_pcq_head),
        .full_o   (w_pcq_full),
        .empty_o  (w_pcq_empty),
        .count_o  (w_inflight)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch_queue (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push_i   (w_pfq_push),
        .data_i   (w_pfq_in),
        .pop_i    (w_pfq_pop),
        .flush_i  (redirect_valid_i),
        .head_o   (w_pfq_head),
        .full_o   (w_pfq_full),
        .empty_o  (w_pfq_empty),
        .count_o  (w_occupancy)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= S_BOOT;
            r_fetch_pc <= word_align(RESET_PC);
            r_discard  <= '0;
        end else begin
            if (r_state == S_BOOT) r_state <= S_RUN;
            if (redirect_valid_i) begin
                r_fetch_pc <= word_align(redirect_pc_i);
                r_discard  <= w_inflight - CW'(imem_rsp_valid_i);
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (imem_rsp_valid_i && (r_discard != '0)) r_discard <= r_discard - CW'(1);
            end
        end
    end

    always_comb begin
        if_id_o = '0;
        if (w_bypass) begin
            if_id_o.pc    = w_pcq_head.pc;
            if_id_o.instr = imem_rsp_data_i;
        end else if (!w_pfq_empty) begin
            if_id_o.pc    = w_pfq_head.pc;
            if_id_o.instr = w_pfq_head.instr;
        end
        if_id_o.valid = w_out_valid;
    end

    assign w_unused = ^{w_pcq_head.instr, w_pcq_full, w_pcq_empty, w_pfq_full, redirect_pc_i[1:0]};

endmodule
